pe_a10_adder_pipe: RTL
======================

// Module: pe_a10_adder_pipe
// PURPOSE
//  Multi-lane, pipelined successor to the single sign-magnitude pair adder in the PE datapath.
//  Each lane adds two sign-magnitude operands and produces a two's-complement result.
//  Valid/ready flow control on input and output; full throughput when unstalled.
//  Optional ACCUM mode sums a packet of beats per lane (saturating) and emits one result per packet.
// PARAMETERS
//  SIZE   4           magnitude bits per operand
//  LANES  4           independent lanes per beat
//  ACC_W  SIZE+8      signed result/accumulator width per lane; must be >= SIZE+2
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            async active-low reset
//  in_valid   in   1            input beat valid
//  in_ready   out  1            block can accept a beat
//  in_a       in   LANES*SIZE   lane i magnitude A at [i*SIZE +: SIZE]
//  in_sign_a  in   LANES        lane i sign of A (1 = negative)
//  in_b       in   LANES*SIZE   lane i magnitude B
//  in_sign_b  in   LANES        lane i sign of B
//  in_mode    in   1            0 = ADD, 1 = ACCUM; sampled only on the first beat of a packet
//  in_last    in   1            last beat of packet (ignored in ADD mode)
//  out_valid  out  1            result valid
//  out_ready  in   1            downstream accepts result
//  out_data   out  LANES*ACC_W  lane i signed result at [i*ACC_W +: ACC_W]
//  out_ovf    out  LANES        lane i saturated at least once in this result
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_data=0, out_ovf=0, in_ready=0 while asserted.
//    All stage valids, accumulators, ovf flags and mode latch cleared; FSM -> FIRST.
//  - Transfer on a port: valid && ready in the same cycle. Data is held stable while valid && !ready.
//  - Conversion: v = sign ? -mag : +mag. -0 yields 0. Lane sum = vA + vB, exact in SIZE+2 bits, sign-extended to ACC_W.
//  - S1 (register): lane sums plus last/mode. S2: accumulator and output register.
//  - ADD latency: 2 cycles from input accept to out_valid.
//  - Stall: S2 advances when s1_valid && (beat emits no output || !out_valid || out_ready).
//    S1 loads when it is empty or S2 advances. in_ready = !s1_valid || S2 advances. No bubble when unstalled.
//  - FSM (packet tracking at input) has states FIRST and MID.
//    - FIRST: an accepted beat latches in_mode. If ACCUM && !in_last -> MID.
//    - MID: an accepted beat with in_last -> FIRST. in_mode is ignored in MID.
//  - ADD beat at S2: out_data = lane sum, out_ovf = 0, out_valid = 1.
//  - ACCUM beat at S2:
//    - acc_next = (first beat ? 0 : acc) + lane sum, saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//    - ovf is sticky per lane across the packet.
//    - Non-last beat: update acc only; no output.
//    - Last beat: out_data = acc_next, out_ovf = sticky ovf | this-beat ovf, out_valid = 1. Then clear acc and ovf.
//    - A single-beat packet (first && last) emits that beat's sum.
//  - out_valid drops the cycle after out_ready unless a new result is loaded in the same cycle.
//  - Reset during a packet discards the partial accumulation. The next accepted beat is a packet first beat.
// STRUCTURE
//  - pe_a10_pkg:
//    - typedef enum logic {PE_MODE_ADD, PE_MODE_ACCUM} pe_mode_e
//    - typedef enum logic {PKT_FIRST, PKT_MID} pe_pkt_state_e
//    - function sm_to_tc(sign, mag)
//    - function sat_add(a, b, w) returning {ovf, sum}
//  - Sub-module pe_a10_adder_lane (per-lane convert, add, S1 register, accumulate/saturate), generated LANES times.
//  - The top holds the FSM, valid/ready control and the output register.
// TESTING (SIZE=4, LANES=2, ACC_W=8 unless noted)
//  - ADD: lane0 A=5+, B=3- ; lane1 A=15-, B=15- -> 2 cycles later out lane0=+2, lane1=-30, ovf=00.
//  - -0 handling: A=0 sign 1, B=0 sign 1 -> 0. A=7-, B=0- -> -7.
//  - Backpressure: 6 back-to-back ADD beats, out_ready low for 5 cycles mid-stream.
//    -> in_ready drops once S1 and S2 are full; all 6 results arrive in order, none lost or duplicated.
//  - ACCUM: 4 beats of lane0 A=4+, B=3+, last on beat 4 -> exactly one out_valid, lane0=+28, ovf=0.
//  - Saturation: ACCUM 10 beats of A=15+, B=15+ (+30 each) -> lane=+127, ovf=1.
//    Next packet of 1 beat (+2) -> +2, ovf=0.
//  - Reset mid-packet: 2 ACCUM beats of +30, then rst_n low for 1 cycle -> out_valid=0.
//    Then a 1-beat ADD packet of +5 -> +5, showing no residue from the discarded packet.

Source files
------------

// File: rtl/pe_a10_pkg.sv
// Shared types and arithmetic helpers for the pipelined sign-magnitude lane adder.
// Helpers work on 32-bit signed values; supported widths are ACC_W in [SIZE+2, 31].
package pe_a10_pkg;

  typedef enum logic {PE_MODE_ADD = 1'b0, PE_MODE_ACCUM = 1'b1} pe_mode_e;
  typedef enum logic {PKT_FIRST = 1'b0, PKT_MID = 1'b1} pe_pkt_state_e;

  // Negative zero collapses to zero naturally through two's-complement negation.
  function automatic logic signed [31:0] sm_to_tc(input logic sign, input logic [31:0] mag);
    return sign ? -$signed(mag) : $signed(mag);
  endfunction

  // Returns {ovf, sum} with sum clamped to the signed range of a w-bit value.
  function automatic logic [32:0] sat_add(input logic signed [31:0] a,
                                          input logic signed [31:0] b,
                                          input int unsigned w);
    logic signed [33:0] sum;
    logic signed [33:0] hi;
    logic signed [33:0] lo;
    sum = 34'(a) + 34'(b);
    hi  = (34'sd1 <<< (w - 1)) - 34'sd1;
    lo  = -(34'sd1 <<< (w - 1));
    if (sum > hi) return {1'b1, hi[31:0]};
    if (sum < lo) return {1'b1, lo[31:0]};
    return {1'b0, sum[31:0]};
  endfunction

endpackage

// File: rtl/pe_a10_adder_lane.sv
// One lane: sign-magnitude convert and add into the S1 register, then the
// saturating accumulator feeding the shared output register.
module pe_a10_adder_lane
  import pe_a10_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned ACC_W = SIZE + 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1_load_i,
  input  logic             s2_adv_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic             accum_i,
  input  logic [SIZE-1:0]  a_i,
  input  logic             sign_a_i,
  input  logic [SIZE-1:0]  b_i,
  input  logic             sign_b_i,
  output logic [ACC_W-1:0] res_o,
  output logic             ovf_o
);

  logic signed [31:0]      sum_full;
  logic signed [SIZE+1:0]  sum_d, sum_q;
  logic signed [ACC_W-1:0] sum_ext, base, acc_next, acc_q;
  logic [32:0]             sat;
  logic                    ovf_q, ovf_base, ovf_next;
  logic                    unused_bits;

  assign sum_full = sm_to_tc(sign_a_i, 32'(a_i)) + sm_to_tc(sign_b_i, 32'(b_i));
  assign sum_d    = sum_full[SIZE+1:0];
  assign sum_ext  = ACC_W'(sum_q);

  // A packet's first beat starts from zero regardless of leftover state.
  assign base     = first_i ? '0 : acc_q;
  assign ovf_base = first_i ? 1'b0 : ovf_q;
  assign sat      = sat_add(32'(base), 32'(sum_ext), ACC_W);
  assign acc_next = sat[ACC_W-1:0];
  assign ovf_next = ovf_base | sat[32];

  assign res_o = accum_i ? acc_next : sum_ext;
  assign ovf_o = accum_i & ovf_next;

  assign unused_bits = ^{sum_full[31:SIZE+2], sat[31:ACC_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (s1_load_i) sum_q <= sum_d;
      if (s2_adv_i && accum_i) begin
        if (last_i) begin
          acc_q <= '0;
          ovf_q <= 1'b0;
        end else begin
          acc_q <= acc_next;
          ovf_q <= ovf_next;
        end
      end
    end
  end

endmodule

// File: rtl/pe_a10_adder_pipe.sv
// Multi-lane pipelined sign-magnitude adder with valid/ready flow control and an
// optional per-packet saturating accumulate mode.
module pe_a10_adder_pipe
  import pe_a10_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = SIZE + 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*SIZE-1:0]  in_a,
  input  logic [LANES-1:0]       in_sign_a,
  input  logic [LANES*SIZE-1:0]  in_b,
  input  logic [LANES-1:0]       in_sign_b,
  input  logic                   in_mode,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic [LANES-1:0]       out_ovf
);

  pe_pkt_state_e state_q, state_d;
  pe_mode_e      mode_q, s1_mode_q, beat_mode;
  logic          s1_valid_q, s1_valid_d, s1_first_q, s1_last_q;
  logic          beat_first, beat_last, in_fire, s2_adv;
  logic          out_valid_q;
  logic [LANES*ACC_W-1:0] out_data_q, lane_res;
  logic [LANES-1:0]       out_ovf_q, lane_ovf;

  // s1_last_q means "this beat emits a result": always true for ADD beats.
  assign s2_adv   = s1_valid_q && (!s1_last_q || !out_valid_q || out_ready);
  assign in_ready = rst_n && (!s1_valid_q || s2_adv);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    beat_first = (state_q == PKT_FIRST);
    beat_mode  = beat_first ? pe_mode_e'(in_mode) : mode_q;
    beat_last  = (beat_mode == PE_MODE_ADD) || in_last;
    state_d    = state_q;
    s1_valid_d = s1_valid_q;
    if (in_fire) begin
      unique case (state_q)
        PKT_FIRST: if (beat_mode == PE_MODE_ACCUM && !in_last) state_d = PKT_MID;
        PKT_MID:   if (in_last) state_d = PKT_FIRST;
        default:   state_d = PKT_FIRST;
      endcase
    end
    if (in_fire)     s1_valid_d = 1'b1;
    else if (s2_adv) s1_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PKT_FIRST;
      mode_q      <= PE_MODE_ADD;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= PE_MODE_ADD;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      if (in_fire && beat_first) mode_q <= pe_mode_e'(in_mode);
      if (in_fire) begin
        s1_first_q <= beat_first;
        s1_last_q  <= beat_last;
        s1_mode_q  <= beat_mode;
      end
      if (s2_adv && s1_last_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= lane_res;
        out_ovf_q   <= lane_ovf;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_a10_adder_lane #(
      .SIZE  (SIZE),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .s1_load_i (in_fire),
      .s2_adv_i  (s2_adv),
      .first_i   (s1_first_q),
      .last_i    (s1_last_q),
      .accum_i   (s1_mode_q == PE_MODE_ACCUM),
      .a_i       (in_a[i*SIZE +: SIZE]),
      .sign_a_i  (in_sign_a[i]),
      .b_i       (in_b[i*SIZE +: SIZE]),
      .sign_b_i  (in_sign_b[i]),
      .res_o     (lane_res[i*ACC_W +: ACC_W]),
      .ovf_o     (lane_ovf[i])
    );
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule
